// File: rtl/hazard_pkg.sv
// Shared types and default latencies for the ID-stage hazard scoreboard.
package hazard_pkg;

   typedef enum logic [1:0] {
      KIND_ALU  = 2'd0,
      KIND_LOAD = 2'd1,
      KIND_MUL  = 2'd2,
      KIND_RSVD = 2'd3
   } id_kind_e;

   localparam int DEF_LOAD_LAT = 1;
   localparam int DEF_MUL_LAT  = 4;

endpackage

// File: rtl/sb_entry.sv
// Loadable down-counter that stops at zero; one per tracked register and one for the multiplier.
module sb_entry #(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_en,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q, count_d;

   // A load wins over the decrement so a fresh producer sees its full latency.
   always_comb begin
      count_d = count_q;
      if (load_en)
         count_d = load_val;
      else if (count_q != '0)
         count_d = count_q - CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard detection: per-register result countdowns plus a busy counter
// for the single multiplier; stalls on RAW, WAW and structural conflicts.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int REG_W    = 5,
   parameter int LOAD_LAT = DEF_LOAD_LAT,
   parameter int MUL_LAT  = DEF_MUL_LAT,
   parameter int CNT_W    = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic [REG_W-1:0] id_rd,
   input  logic             id_writes,
   input  logic [1:0]       id_kind,
   input  logic             flush,
   output logic             hazard,
   output logic             pcwrite,
   output logic             IF_ID_write,
   output logic [15:0]      stall_count
);

   localparam int NREG = 2 ** REG_W;

   if (LOAD_LAT > (2 ** CNT_W) - 1 || MUL_LAT > (2 ** CNT_W) - 1) begin : g_bad_lat
      $error("hazard_scoreboard: LOAD_LAT/MUL_LAT do not fit in CNT_W bits");
   end

   id_kind_e         kind;
   logic [CNT_W-1:0] lat_val;
   logic [CNT_W-1:0] cnt [NREG];
   logic [CNT_W-1:0] mul_busy;
   logic             raw, waw, struct_haz, stall, issue;
   logic [15:0]      stall_count_q, stall_count_d;

   assign kind = id_kind_e'(id_kind);

   // Kind 3 is not a real opcode class and behaves like a forwarded ALU op.
   always_comb begin
      lat_val = '0;
      case (kind)
         KIND_LOAD: lat_val = CNT_W'(LOAD_LAT);
         KIND_MUL:  lat_val = CNT_W'(MUL_LAT);
         default:   lat_val = '0;
      endcase
   end

   always_comb begin
      raw = (id_uses_rs && id_rs != '0 && cnt[id_rs] != '0) ||
            (id_uses_rt && id_rt != '0 && cnt[id_rt] != '0);
      waw = id_writes && id_rd != '0 && (cnt[id_rd] > lat_val);
      struct_haz = (kind == KIND_MUL) && (mul_busy != '0);
      stall = id_valid && !flush && (raw || waw || struct_haz);
      issue = id_valid && !flush && !stall;
   end

   assign hazard      = !stall;
   assign pcwrite     = !stall;
   assign IF_ID_write = !stall;

   // r0 is hardwired zero, so it never gets a counter.
   assign cnt[0] = '0;

   for (genvar r = 1; r < NREG; r++) begin : g_reg
      logic load_en;
      assign load_en = issue && id_writes && (id_rd == REG_W'(r));
      sb_entry #(.CNT_W(CNT_W)) u_entry (
         .clk      (clk),
         .rst      (rst),
         .load_en  (load_en),
         .load_val (lat_val),
         .count    (cnt[r])
      );
   end

   sb_entry #(.CNT_W(CNT_W)) u_mul_busy (
      .clk      (clk),
      .rst      (rst),
      .load_en  (issue && kind == KIND_MUL),
      .load_val (CNT_W'(MUL_LAT)),
      .count    (mul_busy)
   );

   always_comb begin
      stall_count_d = stall_count_q;
      if (stall && stall_count_q != 16'hFFFF)
         stall_count_d = stall_count_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         stall_count_q <= '0;
      else
         stall_count_q <= stall_count_d;
   end

   assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed scenarios plus random traffic against a behavioural scoreboard model.
module tb_hazard_scoreboard;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic        id_uses_rs, id_uses_rt, id_writes;
   logic [1:0]  id_kind;
   logic        flush;
   logic        hazard, pcwrite, IF_ID_write;
   logic [15:0] stall_count;

   int checks   = 0;
   int failures = 0;

   int  m_cnt [32];
   int  m_mul;
   int  m_stalls;
   bit  model_ok = 1'b0;

   always #5 clk = ~clk;

   hazard_scoreboard dut (
      .clk         (clk),
      .rst         (rst),
      .id_valid    (id_valid),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_uses_rs  (id_uses_rs),
      .id_uses_rt  (id_uses_rt),
      .id_rd       (id_rd),
      .id_writes   (id_writes),
      .id_kind     (id_kind),
      .flush       (flush),
      .hazard      (hazard),
      .pcwrite     (pcwrite),
      .IF_ID_write (IF_ID_write),
      .stall_count (stall_count)
   );

   function automatic int lat_of(input int k);
      if (k == 1) return 1;
      if (k == 2) return 4;
      return 0;
   endfunction

   // Hazard rules evaluated directly on the pending-cycle counts.
   function automatic bit model_stall();
      bit hz;
      hz = 1'b0;
      if (id_uses_rs && id_rs != 0 && m_cnt[id_rs] > 0) hz = 1'b1;
      if (id_uses_rt && id_rt != 0 && m_cnt[id_rt] > 0) hz = 1'b1;
      if (id_writes && id_rd != 0 && m_cnt[id_rd] > lat_of(int'(id_kind))) hz = 1'b1;
      if (id_kind == 2'd2 && m_mul > 0) hz = 1'b1;
      return id_valid && !flush && hz;
   endfunction

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic check_cnt(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock: apply inputs, check outputs mid-cycle, advance the model at the edge.
   // dir_stall: -1 = no directed expectation, 0/1 = scenario-specific stall value.
   task automatic step(input bit v, input int rs, input bit urs, input int rt, input bit urt,
                       input int rd, input bit wr, input int k, input bit fl, input bit r,
                       input int dir_stall);
      bit st;
      id_valid = v; id_rs = 5'(rs); id_uses_rs = urs; id_rt = 5'(rt); id_uses_rt = urt;
      id_rd = 5'(rd); id_writes = wr; id_kind = 2'(k); flush = fl; rst = r;
      @(negedge clk);
      if (model_ok) begin
         st = model_stall();
         check_bit("hazard", hazard, !st);
         check_bit("pcwrite", pcwrite, !st);
         check_bit("if_id_write", IF_ID_write, !st);
         check_cnt("stall_count", stall_count, 16'(m_stalls));
      end
      if (dir_stall >= 0)
         check_bit("directed_hazard", hazard, dir_stall == 0);
      @(posedge clk);
      if (r) begin
         foreach (m_cnt[i]) m_cnt[i] = 0;
         m_mul = 0; m_stalls = 0; model_ok = 1'b1;
      end else if (model_ok) begin
         st = model_stall();
         if (st && m_stalls < 65535) m_stalls++;
         foreach (m_cnt[i]) if (m_cnt[i] > 0) m_cnt[i]--;
         if (m_mul > 0) m_mul--;
         if (v && !fl && !st) begin
            if (wr && rd != 0) m_cnt[rd] = lat_of(k);
            if (k == 2) m_mul = 4;
         end
      end
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1);
   endtask

   initial begin
      rst = 1'b1; id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
      id_rd = 0; id_writes = 0; id_kind = 0; flush = 0;
      #1;
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, -1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, -1);
      idle(1);
      check_cnt("reset_stall_count", stall_count, 16'd0);
      check_bit("reset_hazard", hazard, 1'b1);

      // LOAD r8 then an ALU reading r8: one bubble.
      step(1, 1, 1, 2, 1, 8, 1, 1, 0, 0, 0);
      step(1, 8, 1, 0, 0, 3, 1, 0, 0, 0, 1);
      step(1, 8, 1, 0, 0, 3, 1, 0, 0, 0, 0);
      idle(1);
      check_cnt("load_use_stall_count", stall_count, 16'd1);
      idle(5);

      // MUL r9 then a reader of rt=r9: four bubbles.
      step(1, 1, 1, 2, 1, 9, 1, 2, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(1, 0, 0, 9, 1, 4, 1, 0, 0, 0, 1);
      step(1, 0, 0, 9, 1, 4, 1, 0, 0, 0, 0);
      idle(5);
      // Same but rt not actually read: no bubble.
      step(1, 1, 1, 2, 1, 9, 1, 2, 0, 0, 0);
      step(1, 0, 0, 9, 0, 4, 1, 0, 0, 0, 0);
      idle(5);

      // Back-to-back independent MULs: structural stall cycles 1-4.
      step(1, 1, 1, 2, 1, 10, 1, 2, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(1, 3, 1, 4, 1, 11, 1, 2, 0, 0, 1);
      step(1, 3, 1, 4, 1, 11, 1, 2, 0, 0, 0);
      idle(6);

      // Writes to r0 are never tracked.
      step(1, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0);
      step(1, 0, 1, 0, 1, 5, 1, 0, 0, 0, 0);
      step(1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0);
      idle(2);

      // Flush during a RAW stall: no bubble, pending count keeps draining.
      step(1, 1, 1, 2, 1, 9, 1, 2, 0, 0, 0);
      step(1, 9, 1, 0, 0, 6, 1, 0, 0, 0, 1);
      step(1, 9, 1, 0, 0, 6, 1, 0, 1, 0, 0);
      step(1, 9, 1, 0, 0, 6, 1, 0, 0, 0, 1);
      step(1, 9, 1, 0, 0, 6, 1, 0, 0, 0, 1);
      step(1, 9, 1, 0, 0, 6, 1, 0, 0, 0, 0);
      idle(5);

      // WAW: LOAD to a register with a MUL still outstanding.
      step(1, 1, 1, 2, 1, 12, 1, 2, 0, 0, 0);
      step(1, 0, 0, 0, 0, 12, 1, 1, 0, 0, 1);
      step(1, 0, 0, 0, 0, 12, 1, 1, 0, 0, 1);
      step(1, 0, 0, 0, 0, 12, 1, 1, 0, 0, 1);
      step(1, 0, 0, 0, 0, 12, 1, 1, 0, 0, 0);
      idle(5);

      // MUL r5, reset in the middle of the resulting stall, then no stall.
      step(1, 1, 1, 2, 1, 5, 1, 2, 0, 0, 0);
      step(1, 5, 1, 0, 0, 7, 1, 0, 0, 1, 1);
      step(1, 5, 1, 0, 0, 7, 1, 0, 0, 0, 0);
      check_cnt("post_reset_stall_count", stall_count, 16'd0);
      idle(5);

      // Saturation: preload the counter near its maximum, then stall repeatedly.
      step(1, 1, 1, 2, 1, 5, 1, 2, 0, 0, 0);
      force dut.stall_count_q = 16'hFFFE;
      #1;
      release dut.stall_count_q;
      m_stalls = 65534;
      for (int i = 0; i < 4; i++) step(1, 5, 1, 0, 0, 7, 1, 0, 0, 0, 1);
      check_cnt("saturated_stall_count", stall_count, 16'hFFFF);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, -1);
      idle(2);

      // Random traffic over a small register window so hazards are frequent.
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 9) != 0, $urandom_range(0, 7), $urandom_range(0, 1) != 0,
              $urandom_range(0, 7), $urandom_range(0, 1) != 0, $urandom_range(0, 7),
              $urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 9) == 0,
              $urandom_range(0, 99) == 0, -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
